serial_frame_deserializer: RTL and testbench

Downstream consumer of the 8-bit serial shift register's Serial_Data_Out stream. Hunts for a start bit, shifts in one data frame at one bit per clock, and checks optional parity and the stop bit. Each good frame is presented as a parallel word on a valid/ready handshake, with sticky error flags and a good-frame counter for debug.

---
 rtl/serial_frame_deserializer.sv | 111 +++++++++++
 tb/tb_serial_frame_deserializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: hunts for a start bit, shifts in DATA_WIDTH data bits,
// checks optional parity and the stop bit, and presents good words on valid/ready.
module serial_frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Serial_Data_In,
  input  logic                  Data_Ready_In,
  input  logic                  Clear_Errors_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Parity_Error_Out,
  output logic                  Framing_Error_Out,
  output logic                  Overrun_Error_Out,
  output logic [15:0]           Frame_Count_Out,
  output logic                  Busy_Out,
  output logic [1:0]            Fsm_State_Out
);

  // Handshake: a word transfers on any rising edge where Data_Valid_Out and
  // Data_Ready_In are both high; Data_Out holds steady until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  localparam int CW = $clog2(DATA_WIDTH);

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;

  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  par_ok;
  logic                  consume;
  logic                  good;
  logic                  load;
  logic                  set_p;
  logic                  set_f;
  logic                  set_o;

  // Shifting instead of indexing: after DATA_WIDTH bits the first bit lands
  // at bit 0 (LSB first) or at the top bit (MSB first).
  always_comb begin
    shift_nxt = (LSB_FIRST != 0) ? {Serial_Data_In, shift_q[DATA_WIDTH-1:1]}
                                 : {shift_q[DATA_WIDTH-2:0], Serial_Data_In};
    par_ok    = (PARITY_EN == 0) || ((^shift_q ^ par_q) == 1'(PARITY_ODD));
    consume   = Data_Valid_Out && Data_Ready_In;
    set_f     = (state == STOP) && Serial_Data_In;
    set_p     = (state == STOP) && !Serial_Data_In && !par_ok;
    good      = (state == STOP) && !Serial_Data_In && par_ok;
    load      = good && (!Data_Valid_Out || consume);
    set_o     = good && !load;
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      shift_q           <= '0;
      par_q             <= 1'b0;
      Data_Out          <= '0;
      Data_Valid_Out    <= 1'b0;
      Parity_Error_Out  <= 1'b0;
      Framing_Error_Out <= 1'b0;
      Overrun_Error_Out <= 1'b0;
      Frame_Count_Out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Serial_Data_In) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          shift_q <= shift_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_q <= Serial_Data_In;
          state <= STOP;
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        Data_Out        <= shift_q;
        Data_Valid_Out  <= 1'b1;
        Frame_Count_Out <= Frame_Count_Out + 16'd1;
      end else if (consume) begin
        Data_Valid_Out  <= 1'b0;
      end

      // A flag setting on the same edge as a clear stays set.
      Parity_Error_Out  <= set_p || (Parity_Error_Out  && !Clear_Errors_In);
      Framing_Error_Out <= set_f || (Framing_Error_Out && !Clear_Errors_In);
      Overrun_Error_Out <= set_o || (Overrun_Error_Out && !Clear_Errors_In);
    end
  end

  assign Busy_Out      = (state != IDLE);
  assign Fsm_State_Out = state;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Randomized bench for serial_frame_deserializer: frames are built from data,
// parity and stop fields, and a transaction-level model predicts every output.
module tb_serial_frame_deserializer;

  localparam int DW   = 8;
  localparam int PEN  = 1;
  localparam int PODD = 0;
  localparam int LSBF = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sdi;
  logic          rdy;
  logic          clr;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          perr;
  logic          ferr;
  logic          oerr;
  logic [15:0]   count;
  logic          busy;
  logic [1:0]    fsm_state;

  serial_frame_deserializer #(
    .DATA_WIDTH(DW), .PARITY_EN(PEN), .PARITY_ODD(PODD), .LSB_FIRST(LSBF)
  ) dut (
    .Clk_In(clk), .Reset_In(rst_n), .Serial_Data_In(sdi),
    .Data_Ready_In(rdy), .Clear_Errors_In(clr),
    .Data_Out(data_out), .Data_Valid_Out(valid),
    .Parity_Error_Out(perr), .Framing_Error_Out(ferr), .Overrun_Error_Out(oerr),
    .Frame_Count_Out(count), .Busy_Out(busy), .Fsm_State_Out(fsm_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the holding register, counter and sticky flags.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [15:0]   m_count;
  logic          m_perr, m_ferr, m_oerr;

  // Outcome of the frame currently being sent, applied on its stop edge.
  logic          f_perr, f_ferr;
  logic [DW-1:0] f_word;

  int   ready_mode = 1;  // 0 low, 1 high, 2 random, 3 high only on stop edges
  logic clr_next   = 1'b0;
  logic rand_clr   = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_count = '0;
    m_perr = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
  endtask

  task automatic compare_all(input logic exp_busy);
    check("data",  16'(data_out), 16'(m_data));
    check("valid", 16'(valid),    16'(m_valid));
    check("count", count,         m_count);
    check("perr",  16'(perr),     16'(m_perr));
    check("ferr",  16'(ferr),     16'(m_ferr));
    check("oerr",  16'(oerr),     16'(m_oerr));
    check("busy",  16'(busy),     16'(exp_busy));
  endtask

  // Called at a falling edge; drives one serial bit, models the rising edge.
  task automatic step(input logic s, input logic at_stop, input logic exp_busy);
    logic r, c, consumed, sp, sf, so;
    case (ready_mode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = 1'($urandom_range(0, 1));
      default: r = at_stop;
    endcase
    c = clr_next || (rand_clr && ($urandom_range(0, 19) == 0));
    clr_next = 1'b0;
    sdi = s; rdy = r; clr = c;
    @(posedge clk);
    consumed = m_valid && r;
    if (consumed) m_valid = 1'b0;
    sp = 1'b0; sf = 1'b0; so = 1'b0;
    if (at_stop) begin
      if (f_ferr) sf = 1'b1;
      else if (f_perr) sp = 1'b1;
      else if (!m_valid) begin
        m_data = f_word; m_valid = 1'b1; m_count = m_count + 16'd1;
      end else so = 1'b1;
    end
    m_perr = sp || (m_perr && !c);
    m_ferr = sf || (m_ferr && !c);
    m_oerr = so || (m_oerr && !c);
    #1 compare_all(exp_busy);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pflip,
                            input logic stop_bit, input int gap);
    logic pbit;
    pbit   = logic'(($countones(d) + PODD) % 2) ^ pflip;
    f_word = d;
    f_ferr = stop_bit;
    f_perr = ((($countones(d) + int'(pbit)) % 2) != PODD);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DW; i++) step(LSBF != 0 ? d[i] : d[DW-1-i], 1'b0, 1'b1);
    if (PEN != 0) step(pbit, 1'b0, 1'b1);
    step(stop_bit, 1'b1, 1'b0);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Entered at a falling edge; asserts reset between edges and checks it
  // took effect without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    sdi = 1'b0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    #1 compare_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sdi = 1'b0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Good 0xA5 frame, then consumed on the next edge.
    ready_mode = 1;
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    check("a5_word",  16'(data_out), 16'h00A5);
    check("a5_valid", 16'(valid), 16'd1);
    step(1'b0, 1'b0, 1'b0);
    check("a5_consumed", 16'(valid), 16'd0);

    // Parity error, then clear.
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    check("par_flag",  16'(perr), 16'd1);
    check("par_count", count, 16'd0);
    clr_next = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("par_cleared", 16'(perr), 16'd0);

    // Framing error, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    check("frm_flag", 16'(ferr), 16'd1);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("frm_next_word", 16'(data_out), 16'h003C);

    // Overrun with back-to-back frames while the consumer stalls.
    do_reset();
    ready_mode = 0;
    send_frame(8'h11, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0);
    check("ovr_word",  16'(data_out), 16'h0011);
    check("ovr_flag",  16'(oerr), 16'd1);
    check("ovr_count", count, 16'd1);
    ready_mode = 1;
    step(1'b0, 1'b0, 1'b0);
    check("ovr_drained", 16'(valid), 16'd0);

    // Consume and reload on the same stop edge.
    do_reset();
    ready_mode = 0;
    send_frame(8'h55, 1'b0, 1'b0, 0);
    ready_mode = 3;
    send_frame(8'h66, 1'b0, 1'b0, 0);
    check("swap_word",  16'(data_out), 16'h0066);
    check("swap_valid", 16'(valid), 16'd1);
    check("swap_oerr",  16'(oerr), 16'd0);
    check("swap_count", count, 16'd2);

    // Reset in the middle of a frame discards it.
    do_reset();
    ready_mode = 1;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    do_reset();
    check("rst_busy", 16'(busy), 16'd0);
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    check("rst_word",  16'(data_out), 16'h000F);
    check("rst_count", count, 16'd1);

    // Randomized frames, ready and clears.
    ready_mode = 2;
    rand_clr   = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send_frame(DW'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
